// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, tx FSM state encoding and baud divisor helper.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned DATA_BITS     = 8;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t StIdle   = 3'd0;
  localparam tx_state_t StStart  = 3'd1;
  localparam tx_state_t StData   = 3'd2;
  localparam tx_state_t StParity = 3'd3;
  localparam tx_state_t StStop   = 3'd4;

  // Board cycles per 16x tick, truncated; never below 1 so the tick can always fire.
  function automatic int unsigned calc_div(input int unsigned board_freq,
                                           input int unsigned baud_rate);
    int unsigned div;
    if (baud_rate == 0) begin
      return 1;
    end
    div = board_freq / (TICKS_PER_BIT * baud_rate);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_baud_tick_gen.sv
// 16x oversampling tick generator; freezes with enable and can be restarted synchronously.
`timescale 1ns/1ps
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned board_freq = 50000000,
  parameter int unsigned baud_rate  = 9600
) (
  input  logic clk_board,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick,
  output logic tick_next
);

  localparam int unsigned Div     = calc_div(board_freq, baud_rate);
  localparam int unsigned CntW    = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned NextIdx = (Div > 1) ? Div - 2 : 0;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == CntW'(Div - 1));
  // High when the following enabled cycle will carry a tick (Div=1 ticks every cycle).
  assign tick_next = enable && (cnt_q == CntW'(NextIdx));

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CntW'(Div - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_board or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-deep holding register, LSB-first shifter, optional parity, idle-high line.
`timescale 1ns/1ps
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned board_freq = 50000000,
  parameter int unsigned baud_rate  = 9600,
  parameter bit          parity_en  = 1'b0,
  parameter bit          parity_odd = 1'b0
) (
  input  logic                 clk_board,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 load,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 tx
);

  localparam int unsigned TickW = $clog2(TICKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_BITS);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic                 par_q, par_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 tx_q, tx_d;

  logic tick, tick_next, restart, take, accept, bit_end;

  baud_tick_gen #(
    .board_freq(board_freq),
    .baud_rate (baud_rate)
  ) u_tick (
    .clk_board(clk_board),
    .reset    (reset),
    .enable   (enable),
    .restart  (restart),
    .tick     (tick),
    .tick_next(tick_next)
  );

  assign accept  = load && ready_q;
  assign bit_end = tick && (tick_cnt_q == TickW'(TICKS_PER_BIT - 1));

  always_comb begin : p_fsm
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    tick_cnt_d = tick_cnt_q;
    par_d      = par_q;
    take       = 1'b0;
    restart    = 1'b0;
    if (enable) begin
      if (state_q != StIdle && tick) begin
        tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (!ready_q) begin
            take       = 1'b1;
            restart    = 1'b1;
            tick_cnt_d = '0;
            state_d    = StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_d = StData;
          end
        end
        StData: begin
          if (bit_end) begin
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
              state_d = parity_en ? StParity : StStop;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_d = StStop;
          end
        end
        StStop: begin
          if (bit_end) begin
            // A queued byte starts immediately so consecutive frames have no idle gap.
            if (!ready_q) begin
              take    = 1'b1;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
    if (take) begin
      shift_d   = hold_q;
      par_d     = (^hold_q) ^ parity_odd;
      bit_cnt_d = '0;
    end
  end

  always_comb begin : p_out
    hold_d  = accept ? data : hold_q;
    ready_d = ready_q;
    if (accept) begin
      ready_d = 1'b0;
    end else if (take) begin
      ready_d = 1'b1;
    end
    error_d = load && !ready_q;
    busy_d  = (state_d != StIdle);
    // Registered done must lead the final stop tick by one cycle.
    done_d  = enable && (state_q == StStop) && tick_next &&
              (({1'b0, tick_cnt_q} + (TickW + 1)'(tick)) == (TickW + 1)'(TICKS_PER_BIT - 1));
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_board or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      hold_q     <= '0;
      bit_cnt_q  <= '0;
      tick_cnt_q <= '0;
      par_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      bit_cnt_q  <= bit_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      par_q      <= par_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      tx_q       <= tx_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: scoreboard of queued bytes checked bit-by-bit on the line.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data;
  logic [2:0] load_v;
  logic [2:0] ready_v, busy_v, done_v, error_v, tx_v;

  int n_checks = 0;
  int n_errors = 0;
  byte unsigned exp_q[$];
  int unsigned done_cnt0 = 0;
  int unsigned err_cnt0  = 0;
  int unsigned snap_done, snap_err;

  always #5 clk = ~clk;

  // 0: no parity, 1: even parity, 2: odd parity; DIV = 160/(16*10) = 1.
  uart_tx #(.board_freq(160), .baud_rate(10), .parity_en(1'b0), .parity_odd(1'b0)) u_dut (
    .clk_board(clk), .reset(reset), .enable(enable), .data(data), .load(load_v[0]),
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0]), .tx(tx_v[0])
  );
  uart_tx #(.board_freq(160), .baud_rate(10), .parity_en(1'b1), .parity_odd(1'b0)) u_even (
    .clk_board(clk), .reset(reset), .enable(enable), .data(data), .load(load_v[1]),
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1]), .tx(tx_v[1])
  );
  uart_tx #(.board_freq(160), .baud_rate(10), .parity_en(1'b1), .parity_odd(1'b1)) u_odd (
    .clk_board(clk), .reset(reset), .enable(enable), .data(data), .load(load_v[2]),
    .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .error(error_v[2]), .tx(tx_v[2])
  );

  always @(posedge clk) begin
    done_cnt0 <= done_cnt0 + {31'd0, done_v[0]};
    err_cnt0  <= err_cnt0 + {31'd0, error_v[0]};
  end

  task automatic step();
    @(posedge clk);
    #1;
    load_v = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int sel);
    chk("idle_tx", {31'd0, tx_v[sel]}, 32'd1);
    chk("idle_busy", {31'd0, busy_v[sel]}, 32'd0);
    chk("idle_ready", {31'd0, ready_v[sel]}, 32'd1);
  endtask

  // Pops the next expected byte and checks each line cycle of its frame, starting at
  // start-bit cycle 'first'; optional freeze inside bit fz_bit, optional abort at abort_bit.
  task automatic check_frame(input int sel, input int first, input int fz_bit,
                             input int fz_cyc, input int abort_bit);
    logic [7:0]  b;
    logic [10:0] bits;
    int          nb;
    chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() == 0) return;
    b = exp_q.pop_front();
    bits = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    nb = 9;
    if (sel == 1) begin
      bits[9] = ^b;
      nb = 10;
    end else if (sel == 2) begin
      bits[9] = ~^b;
      nb = 10;
    end
    bits[nb] = 1'b1;
    nb++;
    for (int k = 0; k < nb; k++) begin
      if (k == abort_bit) return;
      for (int c = 0; c < 16; c++) begin
        if (k == 0 && c < first) continue;
        chk($sformatf("tx_bit%0d_c%0d", k, c), {31'd0, tx_v[sel]}, {31'd0, bits[k]});
        chk("frame_busy", {31'd0, busy_v[sel]}, 32'd1);
        chk("frame_done", {31'd0, done_v[sel]}, {31'd0, (k == nb - 1) && (c == 15)});
        if (k == fz_bit && c == fz_cyc) begin
          enable = 1'b0;
          repeat (40) begin
            step();
            chk("frozen_tx", {31'd0, tx_v[sel]}, {31'd0, bits[k]});
          end
          enable = 1'b1;
        end
        step();
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    data   = 8'h00;
    load_v = '0;
    #1;
    repeat (3) step();
    for (int s = 0; s < 3; s++) begin
      chk_idle(s);
      chk("rst_done", {31'd0, done_v[s]}, 32'd0);
      chk("rst_error", {31'd0, error_v[s]}, 32'd0);
    end
    reset = 1'b1;
    repeat (200) begin
      step();
      chk("idle_line", {29'd0, tx_v}, 32'd7);
    end

    // Single byte, no parity: start bit two cycles after load.
    data = 8'hA5; load_v[0] = 1'b1; exp_q.push_back(8'hA5);
    step();
    chk("load_ready_low", {31'd0, ready_v[0]}, 32'd0);
    chk("load_tx_idle", {31'd0, tx_v[0]}, 32'd1);
    chk("load_no_error", {31'd0, error_v[0]}, 32'd0);
    step();
    check_frame(0, 0, -1, -1, -1);
    chk_idle(0);
    chk("after_done_low", {31'd0, done_v[0]}, 32'd0);

    // Parity: even then odd on 0x07.
    data = 8'h07; load_v[1] = 1'b1; exp_q.push_back(8'h07);
    step(); step();
    check_frame(1, 0, -1, -1, -1);
    chk_idle(1);
    data = 8'h07; load_v[2] = 1'b1; exp_q.push_back(8'h07);
    step(); step();
    check_frame(2, 0, -1, -1, -1);
    chk_idle(2);

    // Back-to-back: second frame follows the first stop bit with no gap.
    snap_done = done_cnt0;
    data = 8'h55; load_v[0] = 1'b1; exp_q.push_back(8'h55);
    step(); step();
    chk("b2b_ready_back", {31'd0, ready_v[0]}, 32'd1);
    data = 8'h0F; load_v[0] = 1'b1; exp_q.push_back(8'h0F);
    check_frame(0, 0, -1, -1, -1);
    chk("b2b_no_gap_tx", {31'd0, tx_v[0]}, 32'd0);
    chk("b2b_no_gap_busy", {31'd0, busy_v[0]}, 32'd1);
    check_frame(0, 0, -1, -1, -1);
    chk_idle(0);
    chk("b2b_done_pulses", done_cnt0 - snap_done, 32'd2);

    // Overrun: third byte hits a full holding register and is dropped.
    snap_err = err_cnt0;
    data = 8'h11; load_v[0] = 1'b1; exp_q.push_back(8'h11);
    step(); step();
    data = 8'h22; load_v[0] = 1'b1; exp_q.push_back(8'h22);
    chk("ovr_start", {31'd0, tx_v[0]}, 32'd0);
    step();
    chk("ovr_full", {31'd0, ready_v[0]}, 32'd0);
    data = 8'h33; load_v[0] = 1'b1;
    step();
    chk("ovr_error", {31'd0, error_v[0]}, 32'd1);
    check_frame(0, 2, -1, -1, -1);
    chk("ovr_no_gap", {31'd0, tx_v[0]}, 32'd0);
    check_frame(0, 0, -1, -1, -1);
    chk_idle(0);
    chk("ovr_error_pulses", err_cnt0 - snap_err, 32'd1);
    chk("ovr_sb_empty", exp_q.size(), 32'd0);

    // Freeze mid data bit 3, then reset mid-frame with a byte still held.
    snap_done = done_cnt0;
    data = 8'h3C; load_v[0] = 1'b1; exp_q.push_back(8'h3C);
    step(); step();
    data = 8'h99; load_v[0] = 1'b1;
    check_frame(0, 0, 4, 6, 6);
    repeat (5) step();
    chk("pre_rst_held", {31'd0, ready_v[0]}, 32'd0);
    chk("pre_rst_busy", {31'd0, busy_v[0]}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_tx", {31'd0, tx_v[0]}, 32'd1);
    chk("async_rst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("async_rst_ready", {31'd0, ready_v[0]}, 32'd1);
    repeat (3) step();
    reset = 1'b1;
    repeat (40) step();
    chk_idle(0);
    chk("rst_no_done", done_cnt0 - snap_done, 32'd0);
    chk("final_sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, 8N1 with optional parity. It is the send-side counterpart of the existing 16x-oversampled receiver path.
- Runs on the board clock. Generates its own 16x bit tick internally from board_freq/baud_rate, so receiver and transmitter share the same bit timing.
- Accepts bytes through a one-deep holding register with a load/ready handshake and drives the idle-high tx line.
- Sits beside the receiver under the top-level wrapper, fed by control logic or a loopback path.

Parameters:
board_freq, 50000000, board clock frequency in Hz
baud_rate, 9600, line bit rate in bit/s
parity_en, 0, 1 = append parity bit after data bits
parity_odd, 0, 1 = odd parity, 0 = even (only when parity_en=1)

Ports:
clk_board  input  1  board clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = run; 0 = freeze tick counter and FSM, tx holds its level
data  input  8  byte to send; sampled only on an accepted load
load  input  1  single-cycle request to queue data
ready  output  1  holding register empty; load accepted only when ready=1
busy  output  1  a frame is in progress (START..STOP)
done  output  1  one-cycle pulse at end of each stop bit
error  output  1  one-cycle pulse when load=1 while ready=0 (byte dropped)
tx  output  1  serial line, idle high

Behaviour:
- Reset (reset=0, async) values: tx=1, ready=1, busy=0, done=0, error=0. FSM goes to IDLE; tick and bit counters clear; holding register is invalidated. Reset mid-frame aborts the frame immediately with tx=1.
- Divisor DIV = board_freq/(16*baud_rate), integer truncation; a result of 0 is clamped to 1. A tick pulses once every DIV cycles while enable=1. Bit period = 16 ticks = 16*DIV cycles (default 325 → 5200 cycles).
- Handshake:
  - load&&ready: data is copied to the holding register; ready=0 from the next cycle.
  - load&&!ready: byte is ignored, error=1 for one cycle, no state change.
  - load is honoured even when enable=0 (the register is written, the FSM stays frozen).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, busy=0. If the holding register is valid, move it into the shifter, set ready=1, go to START next cycle; the tick counter restarts so the start bit is full length.
  - Latency: load at cycle N with IDLE and enable=1 → tx=0 and busy=1 at cycle N+2.
  - START: tx=0 for 16 ticks → DATA.
  - DATA: tx=shifter[0], LSB first; shift right every 16 ticks. After 8 bits → PARITY if parity_en, else STOP.
  - PARITY: tx = XOR of the 8 data bits XOR parity_odd, for 16 ticks → STOP.
  - STOP: tx=1 for 16 ticks. At the final tick done=1 for one cycle. Then, if the holding register is valid, go straight to START (no idle gap); otherwise go to IDLE.
- Holding register may be refilled as soon as it transfers to the shifter, including during START. The shifter and holding register are never simultaneously overwritten.
- Same-cycle transfer and load: ready reflects the registered state. A load in the transfer cycle sees ready=0, is rejected and flags error.
- enable=0: tick counter, bit counter and FSM hold; tx, busy and ready are unchanged. Resuming continues mid-bit from the held count.
- All outputs are registered. tx is glitch-free.

Decomposition:
- Package uart_pkg:
  - tx FSM state enum (shared style with the receiver)
  - TICKS_PER_BIT=16, DATA_BITS=8
  - constant function computing DIV with clamp
- One sub-module, baud_tick_gen (board_freq, baud_rate): produces the 16x tick from clk_board/reset/enable, with a synchronous restart input. Reusable to replace the receiver-side clock divider later.
- Top of uart_tx contains the handshake, holding register, shifter and FSM.

Test Plan:
- Bench uses board_freq=160, baud_rate=10 (DIV=1, 16 cycles/bit).
- Reset then idle: hold reset=0 for 3 cycles → tx=1, ready=1, busy=0. No activity for 200 cycles → tx stays 1.
- Single byte 0xA5, parity_en=0: load at cycle N → tx=0 from N+2 for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then stop=1. done pulses at N+161. busy=0 and ready=1 afterwards.
- Parity: 0x07 with parity_en=1, parity_odd=0 → parity bit 1 and frame of 176 cycles. Repeat with parity_odd=1 → parity bit 0.
- Back-to-back: load 0x55, then 0x0F once ready returns to 1 → second start bit begins the cycle after the first done; no idle cycles; 2 done pulses.
- Overrun: load 0x11, 0x22, 0x33 on consecutive ready-allowed cycles → 0x33 is rejected with an error pulse. Line carries 0x11 then 0x22 only.
- Enable freeze and reset: deassert enable mid-bit 3 for 40 cycles → tx constant, and the bit still lasts 16 enabled cycles. Then assert reset=0 mid-data → tx=1 and busy=0 immediately, and the holding register is cleared.
